booth_mul_seq: RTL and testbench

- Sequential signed 32x32 multiplier using radix-4 (bit-pair) Booth recoding; it is the multiply counterpart to the team's divide unit.
- Feeds the ALU result path and writes a 64-bit product packed {HI, LO} into the HI/LO register pair.
- Packing matches the divider's {upper, lower} 64-bit layout, so the ALU output mux treats MUL and DIV alike.
- Multi-cycle with a start/busy/done handshake; the control unit stalls on busy.

---
 rtl/booth_mul_seq.sv | 89 ++++++++
 tb/tb_booth_mul_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed WIDTH x WIDTH radix-4 Booth multiplier, {HI,LO} product
// Two guard bits on A and M keep the +/-2M step exact even for M = -2^(WIDTH-1).
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2) > 0 ? $clog2(WIDTH / 2) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      m_q, m_d, a_q, a_d, addend, a_sum;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    always_comb begin
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = m_q << 1;
            3'b100:         addend = -(m_q << 1);
            3'b101, 3'b110: addend = -m_q;
            default:        addend = '0;
        endcase
        a_sum   = a_q + addend;
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: if (start) begin
                m_d     = {{2{multiplicand[WIDTH-1]}}, multiplicand};
                a_d     = '0;
                q_d     = multiplier;
                qm1_d   = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d   = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
                q_d   = {a_sum[1:0], q_q[WIDTH-1:2]};
                qm1_d = q_q[1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH / 2 - 1)) begin
                    state_d = FIN;
                    prod_d  = {a_d[WIDTH-1:0], q_d};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = state_q != IDLE;
    assign done    = state_q == FIN;
    assign product = prod_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: random and directed checks of booth_mul_seq against a cycle-level product model
module tb_booth_mul_seq;
    localparam int LAT = 17;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy, done;
    logic [63:0] product;

    int n_checks = 0;
    int n_fail = 0;
    bit en = 1'b0;

    int          phase;
    logic [63:0] pend, exp_prod;

    booth_mul_seq #(.WIDTH(32)) dut (
        .clock(clock), .clear_n(clear_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // phase 0 = idle, 1..16 = computing, 17 = result cycle
    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            phase    <= 0;
            exp_prod <= '0;
        end else if (phase == 0) begin
            if (start) begin
                phase <= 1;
                pend  <= $signed(multiplicand) * $signed(multiplier);
            end
        end else if (phase == LAT) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
            if (phase == LAT - 1) exp_prod <= pend;
        end
    end

    always @(negedge clock) begin
        if (en) begin
            chk("busy", 64'(busy), 64'(phase != 0));
            chk("done", 64'(done), 64'(phase == LAT));
            chk("product", product, exp_prod);
        end
    end

    task automatic op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] lit,
                      input bit use_lit, input int inj);
        int n;
        logic [63:0] e;
        e = $signed(m) * $signed(q);
        @(negedge clock);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        multiplicand = m;
        multiplier = q;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == inj) begin
                start = 1'b1;
                multiplicand = 32'd6;
                multiplier = 32'd6;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'(LAT));
        chk("result", product, use_lit ? lit : e);
    endtask

    initial begin
        int last, pulses;
        clear_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        clear_n = 1'b1;
        en = 1'b1;

        op(32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1, 0);
        op(32'h80000000, 32'h80000000, 64'h40000000_00000000, 1, 0);
        op(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1, 0);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1, 0);
        op(32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000, 1, 0);
        op(32'd12345, 32'd0, 64'd0, 1, 0);
        op(32'd0, 32'hFFFFFFFF, 64'd0, 1, 0);
        op(32'd5, 32'd5, 64'd25, 1, 5);

        // abort mid-run: everything must clear immediately
        @(negedge clock);
        multiplicand = 32'd9;
        multiplier = 32'd11;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        #2 clear_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", product, 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
        op(32'd2, 32'd3, 64'd6, 1, 0);

        // start held high: one accepted operation every LAT+1 cycles
        @(negedge clock);
        multiplicand = 32'd4;
        multiplier = 32'd4;
        start = 1'b1;
        last = -1;
        pulses = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (done) begin
                chk("held_product", product, 64'd16);
                if (last >= 0) chk("held_spacing", 64'(c - last), 64'(LAT + 1));
                last = c;
                pulses++;
            end
        end
        start = 1'b0;
        chk("held_pulses", 64'(pulses >= 3), 64'd1);

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] m, q;
            m = $urandom;
            q = $urandom;
            case ($urandom_range(0, 7))
                0: m = 32'h80000000;
                1: q = 32'h80000000;
                2: m = 32'hFFFFFFFF;
                3: q = 32'h7FFFFFFF;
                default: ;
            endcase
            op(m, q, 64'd0, 0, 0);
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
